// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request/response bundle for the shared add/sub arbiter
interface addsub_arbiter_if;
    logic       req0_valid, req0_ready, req0_sub;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_sub;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [3:0] rsp_sum;
    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 4-bit add/sub unit, round-robin on ties.
// Optional per-requester grant counters when ADDSUB_ARB_STATS_EN is defined.
module addsub_arbiter #(
    parameter bit RR_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_arbiter_if.slave  bus_io
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] a_q, b_q, sum_q;
    logic       sub_q, id_q, rid_q, cout_q, ovf_q;
    logic       grant, gnt_id;
    logic [3:0] bx, low;
    logic [4:0] full;

    // Arbitration, ready generation and next-state; ready is gated by rst_n so it drops at once in reset
    always_comb begin
        gnt_id  = bus_io.req1_valid & (~bus_io.req0_valid | ~last_q);
        grant   = rst_n & (state_q == IDLE) & (bus_io.req0_valid | bus_io.req1_valid);
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE:    if (grant) begin
                state_d = EXEC;
                last_d  = gnt_id;
            end
            EXEC:    state_d = RESP;
            RESP:    state_d = bus_io.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.req0_ready = grant & ~gnt_id;
    assign bus_io.req1_ready = grant & gnt_id;

    // Shared datapath: subtraction is A + ~B + 1; overflow is carry into bit 3 XOR carry out
    always_comb begin
        bx   = b_q ^ {4{sub_q}};
        full = {1'b0, a_q} + {1'b0, bx} + {4'b0, sub_q};
        low  = {1'b0, a_q[2:0]} + {1'b0, bx[2:0]} + {3'b0, sub_q};
    end

    // FSM state and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= RR_INIT;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Capture the granted requester's operands so later input changes cannot disturb the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            id_q  <= 1'b0;
        end else if (grant) begin
            a_q   <= gnt_id ? bus_io.req1_a : bus_io.req0_a;
            b_q   <= gnt_id ? bus_io.req1_b : bus_io.req0_b;
            sub_q <= gnt_id ? bus_io.req1_sub : bus_io.req0_sub;
            id_q  <= gnt_id;
        end
    end

    // Register the result in EXEC; it then stays stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            rid_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            sum_q  <= full[3:0];
            cout_q <= full[4];
            ovf_q  <= low[3] ^ full[4];
            rid_q  <= id_q;
        end
    end

    assign bus_io.rsp_valid = (state_q == RESP);
    assign bus_io.rsp_id    = rid_q;
    assign bus_io.rsp_sum   = sum_q;
    assign bus_io.rsp_cout  = cout_q;
    assign bus_io.rsp_ovf   = ovf_q;

`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    // Per-requester grant counters, wrapping at 256
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_q + {7'b0, bus_io.req0_ready};
            cnt1_q <= cnt1_q + {7'b0, bus_io.req1_ready};
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed table, corner sequences and randomized transaction-level check
module tb_addsub_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_arbiter_if bus();
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0] gc0, gc1;
`endif

    addsub_arbiter #(.RR_INIT(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_io(bus.slave)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .grant_cnt0(gc0),
        .grant_cnt1(gc1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit       id;
        logic [3:0] a, b;
        bit       sub;
        logic [3:0] sum;
        bit       cout, ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic set_req(input bit id, input logic [3:0] a, input logic [3:0] b, input bit sub);
        if (id) begin
            bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
        end else begin
            bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
        end
    endtask

    // Reference arithmetic from signed/unsigned integer values
    task automatic ref_op(input logic [3:0] a, input logic [3:0] b, input bit sub,
                          output logic [3:0] s, output bit co, output bit ov);
        int sa, sb, ua, ub, r;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        r  = sub ? sa - sb : sa + sb;
        s  = r[3:0];
        ov = (r > 7) || (r < -8);
        co = sub ? (ua >= ub) : (ua + ub > 15);
    endtask

    initial begin
        bit busy, last_m, gid, v0, v1, rv_exp, eid, eco, eov;
        logic [1:0] exp_r;
        logic [3:0] es;
        int acc, k;
        int exp_gap[4];
        bit exp_id[4];

        tbl[0] = '{0, 4'd3, 4'd2, 0, 4'd5, 0, 0};
        tbl[1] = '{1, 4'h8, 4'h1, 1, 4'h7, 1, 1};
        tbl[2] = '{1, 4'h7, 4'h1, 0, 4'h8, 0, 1};
        tbl[3] = '{0, 4'h0, 4'h0, 1, 4'h0, 1, 0};
        tbl[4] = '{0, 4'hF, 4'hF, 0, 4'hE, 1, 0};
        tbl[5] = '{1, 4'h8, 4'h8, 0, 4'h0, 1, 1};
        tbl[6] = '{0, 4'h2, 4'h5, 1, 4'hD, 0, 0};
        tbl[7] = '{1, 4'h7, 4'h8, 1, 4'hF, 0, 1};

        quiet();
        bus.req0_a = 0; bus.req0_b = 0; bus.req0_sub = 0;
        bus.req1_a = 0; bus.req1_b = 0; bus.req1_sub = 0;
        bus.req0_valid = 1;
        @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf}, 0);
        bus.req0_valid = 0;
        tick();
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub);
            @(negedge clk);
            chk("tbl_ready", {bus.req1_ready, bus.req0_ready}, tbl[i].id ? 2 : 1);
            tick();
            quiet();
            @(negedge clk);
            chk("tbl_exec_rv", bus.rsp_valid, 0);
            tick();
            @(negedge clk);
            chk("tbl_rv", bus.rsp_valid, 1);
            chk("tbl_sum", bus.rsp_sum, tbl[i].sum);
            chk("tbl_cout", bus.rsp_cout, tbl[i].cout);
            chk("tbl_ovf", bus.rsp_ovf, tbl[i].ovf);
            chk("tbl_id", bus.rsp_id, tbl[i].id);
            bus.rsp_ready = 1;
            tick();
            bus.rsp_ready = 0;
        end

        exp_id  = '{0, 1, 0, 1};
        exp_gap = '{0, 3, 6, 9};
        do_reset();
        set_req(0, 4'd1, 4'd1, 0);
        set_req(1, 4'd2, 4'd2, 0);
        bus.rsp_ready = 1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ((bus.req0_ready || bus.req1_ready) && k < 4) begin
                chk("rr_id", bus.req1_ready, exp_id[k]);
                chk("rr_cycle", c, exp_gap[k]);
                k++;
            end
            tick();
        end
        chk("rr_count", k, 4);
        quiet();
        bus.rsp_ready = 1;
        repeat (3) tick();
        bus.rsp_ready = 0;

        set_req(0, 4'd5, 4'd1, 1);
        @(negedge clk);
        chk("hold_ready", bus.req0_ready, 1);
        tick();
        quiet();
        tick();
        for (int c = 0; c < 5; c++) begin
            set_req(0, 4'($urandom), 4'($urandom), 1'($urandom));
            set_req(1, 4'($urandom), 4'($urandom), 1'($urandom));
            @(negedge clk);
            chk("hold_rv", bus.rsp_valid, 1);
            chk("hold_rsp", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf}, {1'b0, 4'd4, 1'b1, 1'b0});
            chk("hold_no_ready", {bus.req1_ready, bus.req0_ready}, 0);
            tick();
        end
        quiet();
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        @(negedge clk);
        chk("hold_release_idle", bus.rsp_valid, 0);
        tick();

        set_req(1, 4'd3, 4'd3, 0);
        @(negedge clk);
        chk("rx_ready1", bus.req1_ready, 1);
        tick();
        quiet();
        rst_n = 0;
        #1;
        chk("rx_rv_now", bus.rsp_valid, 0);
        chk("rx_sum_now", bus.rsp_sum, 0);
        bus.req0_valid = 1;
        #1;
        chk("rx_ready_in_rst", bus.req0_ready, 0);
        tick();
        bus.req0_valid = 0;
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rx_no_rsp", bus.rsp_valid, 0);
            tick();
        end

        do_reset();
        busy = 0; last_m = 1; acc = 0; eid = 0; es = 0; eco = 0; eov = 0; gid = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            bus.req0_valid = v0; bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_sub = 1'($urandom);
            bus.req1_valid = v1; bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_sub = 1'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_r = 2'b00;
            if (!busy && (v0 || v1)) begin
                gid = (v0 && v1) ? !last_m : v1;
                exp_r = gid ? 2'b10 : 2'b01;
            end
            chk("rnd_ready", {bus.req1_ready, bus.req0_ready}, exp_r);
            rv_exp = busy && (cyc >= acc + 2);
            chk("rnd_rv", bus.rsp_valid, rv_exp);
            if (rv_exp) begin
                chk("rnd_rsp", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf}, {eid, es, eco, eov});
                if (bus.rsp_ready) busy = 0;
            end
            if (exp_r != 0) begin
                busy = 1; acc = cyc; last_m = gid; eid = gid;
                if (gid) ref_op(bus.req1_a, bus.req1_b, bus.req1_sub, es, eco, eov);
                else     ref_op(bus.req0_a, bus.req0_b, bus.req0_sub, es, eco, eov);
            end
            tick();
        end
        quiet();

`ifdef ADDSUB_ARB_STATS_EN
        do_reset();
        set_req(0, 4'd1, 4'd2, 0);
        bus.rsp_ready = 1;
        k = 0;
        for (int c = 0; c < 1000 && k < 256; c++) begin
            @(negedge clk);
            if (bus.req0_ready) k++;
            tick();
        end
        chk("stats_grants", k, 256);
        chk("stats_cnt0_wrap", gc0, 0);
        chk("stats_cnt1", gc1, 0);
        quiet();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
